booth_divider: RTL and testbench
================================

# booth_divider

Sequential signed N-bit divider: the inverse of the Booth multiplier datapath. It takes a dividend and a divisor and produces a quotient and remainder in a fixed number of cycles. It uses a non-restoring shift/add-subtract iteration on operand magnitudes, followed by a sign-fix step. It sits beside the multiplier in the arithmetic unit and shares its start/done handshake style and its accumulator/Q-register/counter datapath organisation.

## Interface
- N, 8, operand and result width (two's complement)
- alpha, 3, counter MSB index; counter is [alpha:0] and must hold N
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request pulse; sampled only when busy=0
- data_inQ  in  N  dividend (signed)
- data_inM  in  N  divisor (signed)
- busy  out  1  operation in progress (LOAD, ITER, FIX)
- done  out  1  one-cycle pulse; results valid from this cycle
- quotient  out  N  signed quotient, truncated toward zero
- remainder  out  N  signed remainder; sign follows dividend, or 0
- dbz  out  1  divide-by-zero flag for the last operation
- ovf  out  1  overflow flag: -2^(N-1) / -1

## Operation
- States: IDLE, LOAD, ITER, FIX, DONE.
- IDLE/DONE + start: capture data_inQ and data_inM, then go to LOAD. Any other state ignores start.
- LOAD:
  - latch sign(dividend), sign(divisor), and their XOR;
  - Q reg = |dividend|, M reg = |divisor|, both as N-bit unsigned; |-2^(N-1)| = 2^(N-1);
  - partial remainder A (N+1 bits) = 0; count = N.
  - If divisor == 0, go directly to DONE with quotient = all ones, remainder = dividend, dbz = 1, ovf = 0.
  - Otherwise go to ITER.
- ITER, one step per cycle:
  - shift {A,Q} left by 1;
  - if A ≥ 0 (before the shift), A = A − M, else A = A + M;
  - Q[0] = ~A[N] (new sign);
  - decrement count; leave ITER after the N-th step (count reaches 0).
- FIX:
  - if A < 0, A = A + M (remainder restore);
  - quotient = XOR-sign ? −Q : Q (mod 2^N);
  - remainder = dividend-sign ? −A[N-1:0] : A[N-1:0];
  - ovf = 1 when dividend = 0x80..0 and divisor = all ones; the quotient then wraps to 0x80..0 and the remainder is 0;
  - dbz = 0; go to DONE.
- DONE: done = 1 for exactly this cycle. Then go to IDLE, or to LOAD if start = 1.
- Invariant when dbz = 0: quotient·divisor + remainder == dividend (mod 2^N), and |remainder| < |divisor|.
- quotient, remainder, dbz and ovf are registered. They hold until the next FIX or DONE update. They are not cleared by start.

## Timing
- Reset values: state = IDLE; busy = 0, done = 0; quotient = 0, remainder = 0; dbz = 0, ovf = 0; internal registers = 0.
- Latency: start sampled at edge k → done high in cycle k+N+3 (N = 8: 11 cycles). Divide-by-zero: done in cycle k+2.
- busy is high from cycle k+1 through the FIX cycle. It is low in IDLE and DONE.
- Back-to-back: start held high during DONE is accepted. The next done comes N+3 cycles later, with no idle gap.
- Operand changes after the capture edge have no effect.
- rst asserted mid-operation aborts immediately to the reset values. No done pulse is produced.
- start coincident with rst deassertion edge is ignored.

## Structure
- Shared package holds:
  - the state encoding (3-bit, IDLE = 0);
  - the N/alpha defaults;
  - a localparam for the most-negative value used by the ovf check.
- One natural sub-module: booth_div_addsub, a combinational N+1-bit add/subtract selected by the sign of A. It is shared by ITER and FIX.
- The counter and the registers live in the top module.

## Test plan
- 100 / 7 → quotient 14 (0x0E), remainder 2, dbz 0, ovf 0, done exactly 11 cycles after start.
- −100 / 7 → quotient 0xF2 (−14), remainder 0xFE (−2); 100 / −7 → quotient 0xF2, remainder 2; −100 / −7 → quotient 14, remainder 0xFE.
- −128 / −1 → quotient 0x80, remainder 0, ovf 1. Then −128 / 1 → quotient 0x80, ovf 0.
- 5 / 0 → quotient 0xFF, remainder 5, dbz 1, done 2 cycles after start. The next valid op clears dbz.
- Start pulsed during busy → ignored, first result unchanged. Start held through DONE → second op completes with no gap.
- rst asserted at ITER step 4 → all outputs 0, state IDLE, no done pulse. A fresh 7 / 2 then yields quotient 3, remainder 1.

Source files
------------

// File: rtl/booth_divider_pkg.sv
// Shared definitions for the sequential signed divider: FSM encoding,
// default widths and the most-negative-value helper used by the overflow check.
package booth_divider_pkg;

  localparam int unsigned N_DEF     = 8;
  localparam int unsigned ALPHA_DEF = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  function automatic logic [63:0] most_neg(input int unsigned n);
    return 64'(1) << (n - 1);
  endfunction

  localparam logic [N_DEF-1:0] MOST_NEG = N_DEF'(most_neg(N_DEF));

endpackage

// File: rtl/booth_divider_if.sv
// Start/done handshake and operand/result bus of the divider.
interface booth_divider_if
  import booth_divider_pkg::*;
#(
  parameter int unsigned N = N_DEF
);

  logic         start;
  logic [N-1:0] data_inQ;
  logic [N-1:0] data_inM;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         dbz;
  logic         ovf;

  modport master (
    output start, data_inQ, data_inM,
    input  busy, done, quotient, remainder, dbz, ovf
  );

  modport slave (
    input  start, data_inQ, data_inM,
    output busy, done, quotient, remainder, dbz, ovf
  );

endinterface

// File: rtl/booth_div_addsub.sv
// Combinational add/subtract of the partial remainder: add when A is negative,
// subtract otherwise. Shared by the iteration step and the final restore.
module booth_div_addsub #(
  parameter int unsigned W = 9
) (
  input  logic [W-1:0] operand,
  input  logic [W-1:0] m,
  input  logic         add,
  output logic [W-1:0] result
);

  always_comb begin
    result = add ? (operand + m) : (operand - m);
  end

endmodule

// File: rtl/booth_divider.sv
// Sequential signed divider: non-restoring iteration on operand magnitudes,
// then a sign-fix step. Results are registered and held until the next update.
module booth_divider
  import booth_divider_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned alpha = ALPHA_DEF
) (
  input logic            clk,
  input logic            rst,
  booth_divider_if.slave bus
);

  localparam int unsigned CW = alpha + 1;
  localparam logic [N-1:0] OVF_DIVIDEND =
    (N == N_DEF) ? N'(MOST_NEG) : N'(most_neg(N));

  state_t state, state_nxt;

  logic [N-1:0] dividend_r, divisor_r;
  logic [N-1:0] q_reg, m_reg;
  logic [N:0]   a_reg;
  logic [CW-1:0] count;
  logic         sign_q, sign_m;
  logic [N-1:0] quotient_r, remainder_r;
  logic         dbz_r, ovf_r;

  logic [N-1:0] abs_q, abs_m;
  logic [N:0]   shifted, as_operand, as_result, a_fixed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = LOAD;
      LOAD:    state_nxt = (divisor_r == '0) ? DONE : ITER;
      ITER:    if (count == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = bus.start ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state == LOAD) || (state == ITER) || (state == FIX);
    bus.done      = (state == DONE);
    bus.quotient  = quotient_r;
    bus.remainder = remainder_r;
    bus.dbz       = dbz_r;
    bus.ovf       = ovf_r;
  end

  always_comb begin
    abs_q = dividend_r[N-1] ? ('0 - dividend_r) : dividend_r;
    abs_m = divisor_r[N-1]  ? ('0 - divisor_r)  : divisor_r;
    shifted    = {a_reg[N-1:0], q_reg[N-1]};
    as_operand = (state == ITER) ? shifted : a_reg;
  end

  // The add/sub direction always follows the sign of A before this cycle's shift.
  booth_div_addsub #(.W(N + 1)) u_addsub (
    .operand (as_operand),
    .m       ({1'b0, m_reg}),
    .add     (a_reg[N]),
    .result  (as_result)
  );

  always_comb begin
    a_fixed = a_reg[N] ? as_result : a_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dividend_r  <= '0;
      divisor_r   <= '0;
      q_reg       <= '0;
      m_reg       <= '0;
      a_reg       <= '0;
      count       <= '0;
      sign_q      <= 1'b0;
      sign_m      <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            dividend_r <= bus.data_inQ;
            divisor_r  <= bus.data_inM;
          end
        end
        LOAD: begin
          sign_q <= dividend_r[N-1];
          sign_m <= divisor_r[N-1];
          q_reg  <= abs_q;
          m_reg  <= abs_m;
          a_reg  <= '0;
          count  <= CW'(N);
          if (divisor_r == '0) begin
            quotient_r  <= '1;
            remainder_r <= dividend_r;
            dbz_r       <= 1'b1;
            ovf_r       <= 1'b0;
          end
        end
        ITER: begin
          a_reg <= as_result;
          q_reg <= {q_reg[N-2:0], ~as_result[N]};
          count <= count - CW'(1);
        end
        FIX: begin
          a_reg       <= a_fixed;
          quotient_r  <= (sign_q ^ sign_m) ? ('0 - q_reg) : q_reg;
          remainder_r <= sign_q ? ('0 - a_fixed[N-1:0]) : a_fixed[N-1:0];
          dbz_r       <= 1'b0;
          ovf_r       <= (dividend_r == OVF_DIVIDEND) && (divisor_r == '1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_divider.sv
// Self-checking bench for booth_divider: directed cases plus random operands
// compared against an integer-arithmetic reference model.
module tb_booth_divider;
  import booth_divider_pkg::*;

  localparam int unsigned N = N_DEF;
  localparam int NORMAL_LAT = N + 3;
  localparam int DBZ_LAT    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned total  = 0;
  int unsigned passed = 0;

  logic [N-1:0] dq, dm, dq2, dm2;
  int           lat;
  bit           seen_done;

  booth_divider_if #(.N(N)) bus ();

  booth_divider #(.N(N), .alpha(ALPHA_DEF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: truncating signed division, remainder takes the dividend's sign.
  task automatic model(input logic [N-1:0] a_in, input logic [N-1:0] b_in,
                       output logic [N-1:0] q, output logic [N-1:0] r,
                       output logic z, output logic o);
    int a, b;
    a = int'($signed(a_in));
    b = int'($signed(b_in));
    if (b == 0) begin
      q = '1; r = a_in; z = 1'b1; o = 1'b0;
    end else begin
      q = N'(a / b);
      r = N'(a % b);
      z = 1'b0;
      o = (a == -(2 ** (N - 1))) && (b == -1);
    end
  endtask

  task automatic issue(input logic [N-1:0] a_in, input logic [N-1:0] b_in);
    bus.start    = 1'b1;
    bus.data_inQ = a_in;
    bus.data_inM = b_in;
    tick();
    bus.start    = 1'b0;
    bus.data_inQ = N'($urandom);
    bus.data_inM = N'($urandom);
  endtask

  task automatic wait_done(inout int l);
    while (bus.done !== 1'b1 && l < 40) begin
      tick();
      l++;
    end
  endtask

  task automatic check_result(input string tag, input logic [N-1:0] a_in, input logic [N-1:0] b_in);
    logic [N-1:0] eq, er;
    logic ez, eo;
    model(a_in, b_in, eq, er, ez, eo);
    check($sformatf("%s quotient", tag),  32'(bus.quotient),  32'(eq));
    check($sformatf("%s remainder", tag), 32'(bus.remainder), 32'(er));
    check($sformatf("%s dbz", tag),       32'(bus.dbz),       32'(ez));
    check($sformatf("%s ovf", tag),       32'(bus.ovf),       32'(eo));
    check($sformatf("%s busy in DONE", tag), 32'(bus.busy),   32'(0));
  endtask

  task automatic run_op(input logic [N-1:0] a_in, input logic [N-1:0] b_in, input string tag);
    int l;
    logic [N-1:0] eq, er;
    logic ez, eo;
    model(a_in, b_in, eq, er, ez, eo);
    issue(a_in, b_in);
    check($sformatf("%s busy after start", tag), 32'(bus.busy), 32'(1));
    l = 1;
    wait_done(l);
    check($sformatf("%s latency", tag), 32'(l), 32'(ez ? DBZ_LAT : NORMAL_LAT));
    check_result(tag, a_in, b_in);
    tick();
    check($sformatf("%s done one cycle", tag), 32'(bus.done), 32'(0));
    check($sformatf("%s quotient held", tag), 32'(bus.quotient), 32'(eq));
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.data_inQ = '0;
    bus.data_inM = '0;

    // Reset state
    tick();
    tick();
    check("reset busy",      32'(bus.busy),      32'(0));
    check("reset done",      32'(bus.done),      32'(0));
    check("reset quotient",  32'(bus.quotient),  32'(0));
    check("reset remainder", 32'(bus.remainder), 32'(0));
    check("reset dbz",       32'(bus.dbz),       32'(0));
    check("reset ovf",       32'(bus.ovf),       32'(0));
    rst = 1'b0;
    tick();

    // Sign combinations
    run_op(8'd100, 8'd7, "100/7");
    check("100/7 literal quotient", 32'(bus.quotient), 32'h0E);
    run_op(8'h9C, 8'd7,  "-100/7");
    run_op(8'd100, 8'hF9, "100/-7");
    run_op(8'h9C, 8'hF9, "-100/-7");

    // Overflow boundary and its non-overflow neighbour
    run_op(MOST_NEG, 8'hFF, "-128/-1");
    run_op(MOST_NEG, 8'h01, "-128/1");

    // Divide by zero, then a valid op clears dbz
    run_op(8'd5, 8'd0, "5/0");
    run_op(8'd9, 8'd3, "9/3 after dbz");

    // Start pulsed while busy is ignored
    issue(8'd50, 8'd6);
    tick();
    tick();
    bus.start    = 1'b1;
    bus.data_inQ = 8'd1;
    bus.data_inM = 8'd1;
    tick();
    bus.start = 1'b0;
    lat = 4;
    wait_done(lat);
    check("busy-start latency", 32'(lat), 32'(NORMAL_LAT));
    check_result("busy-start 50/6", 8'd50, 8'd6);
    tick();
    check("busy-start back to idle", 32'(bus.busy), 32'(0));

    // Start held through DONE: second op follows with no gap
    dq = 8'hC4; dm = 8'd5; dq2 = 8'd77; dm2 = 8'hF4;
    issue(dq, dm);
    lat = 1;
    wait_done(lat);
    check("b2b first latency", 32'(lat), 32'(NORMAL_LAT));
    check_result("b2b first", dq, dm);
    issue(dq2, dm2);
    check("b2b second busy", 32'(bus.busy), 32'(1));
    lat = 1;
    wait_done(lat);
    check("b2b second latency", 32'(lat), 32'(NORMAL_LAT));
    check_result("b2b second", dq2, dm2);
    tick();

    // Reset during ITER step 4 aborts with no done pulse
    issue(8'd100, 8'd7);
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("abort busy",      32'(bus.busy),      32'(0));
    check("abort done",      32'(bus.done),      32'(0));
    check("abort quotient",  32'(bus.quotient),  32'(0));
    check("abort remainder", 32'(bus.remainder), 32'(0));
    check("abort dbz",       32'(bus.dbz),       32'(0));
    check("abort ovf",       32'(bus.ovf),       32'(0));
    seen_done = 1'b0;
    repeat (3) begin
      tick();
      if (bus.done === 1'b1) seen_done = 1'b1;
    end
    rst = 1'b0;
    repeat (12) begin
      tick();
      if (bus.done === 1'b1) seen_done = 1'b1;
    end
    check("abort no done pulse", 32'(seen_done), 32'(0));
    run_op(8'd7, 8'd2, "7/2 after abort");
    check("7/2 literal quotient",  32'(bus.quotient),  32'd3);
    check("7/2 literal remainder", 32'(bus.remainder), 32'd1);

    // Random operands
    for (int i = 0; i < 40; i++) begin
      dq = N'($urandom);
      dm = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      if (i % 10 == 0) dq = MOST_NEG;
      if (i % 13 == 0) dm = '1;
      run_op(dq, dm, $sformatf("rand%0d %0d/%0d", i, $signed(dq), $signed(dm)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
